lv1_lv2_bus_arbiter: RTL and testbench
======================================

# lv1_lv2_bus_arbiter

Arbiter for the shared level-1/level-2 bus in the 4-core MESI cache system. It takes processor-side requests from each core's L1 data and L1 instruction caches and snoop-side requests from each core's L1 data cache. It grants one processor owner at a time, round-robin. While that owner holds the bus, it grants at most one snoop responder at a time from the other cores so they can supply data or complete invalidation. It sits between the four core wrappers and the lv2 cache on the lv1–lv2 bus.

## Interface
- NUM_CORES, 4, number of cores; fixed at 4, ids are 2 bits.
- clk  in  1  bus clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- bus_lv1_lv2_req_proc_dl  in  4  per-core L1 data cache processor-side request (bit = core id).
- bus_lv1_lv2_req_proc_il  in  4  per-core L1 instruction cache processor-side request.
- bus_lv1_lv2_req_snoop  in  4  per-core L1 data cache snoop-side request.
- bus_lv1_lv2_gnt_proc_dl  out  4  one-hot processor grant to L1 data caches.
- bus_lv1_lv2_gnt_proc_il  out  4  one-hot processor grant to L1 instruction caches.
- bus_lv1_lv2_gnt_snoop  out  4  one-hot snoop grant.
- bus_owner_id  out  2  core id of the current processor owner; 0 when idle.
- bus_owner_il  out  1  1 when the owner is an instruction cache.
- bus_busy  out  1  1 while any processor grant is asserted.

## Operation
- Requesters are indexed r = 2*core + il, giving the order dl0, il0, dl1, il1, … il3.
- Proc round-robin pointer `last_proc` (3 bits):
  - Search starts at last_proc+1 mod 8, wrapping 7→0.
  - The first asserted request wins.
  - last_proc is loaded with the winner on grant.
- Snoop round-robin pointer `last_snoop` (2 bits):
  - Search starts at last_snoop+1 mod 4.
  - The owner's own core bit is masked out.
  - last_snoop is loaded with the winner on grant.
- States:
  - IDLE: no grants. Any proc request → GRANT, with the winner's grant registered.
  - GRANT: one proc grant held. Sub-flag `snp_act` marks a held snoop grant.
    - Owner request low → RELEASE. All grants (proc and any snoop) clear.
    - Otherwise, if snp_act=0, a snoop pick may set a snoop grant.
    - Otherwise, if snp_act=1 and the held snoop request is low, the snoop grant clears.
  - RELEASE: one-cycle turnaround, all grants low → IDLE. Requests are not evaluated in this state.
- Snoop requests seen in IDLE or RELEASE are ignored, not latched. Requesters hold their request until granted.
- Grants never change while the corresponding request stays high; there is no preemption.
- Invariants (every cycle):
  - popcount(gnt_proc_dl|gnt_proc_il) ≤ 1.
  - popcount(gnt_snoop) ≤ 1.
  - gnt_snoop is nonzero only while bus_busy=1.
  - The gnt_snoop bit never equals bus_owner_id.
- bus_owner_id and bus_owner_il are registered with the grant and zeroed when the grant is low.

## Timing
- Reset (rst high at an edge), including mid-transaction:
  - All grants = 0, bus_busy = 0, bus_owner_id = 0, bus_owner_il = 0.
  - last_proc = 7, last_snoop = 3, state = IDLE.
  - Takes effect at that edge.
- Proc grant latency: request sampled high at edge N (state IDLE) → grant high after edge N (observable in cycle N+1).
- Proc release:
  - Owner request low sampled at edge M → grant low after M (RELEASE).
  - IDLE after M+1.
  - Earliest next grant after M+2.
  - Minimum two low-grant cycles between owners.
- Snoop grant:
  - Request sampled at edge K while in GRANT with snp_act=0 → grant after K.
  - Release one cycle after the request drops.
  - The next snoop grant is evaluated at the following edge, giving one idle cycle between snoop grants.
- Simultaneous owner drop and snoop request at the same edge: the owner drop wins, all grants clear, and last_snoop is unchanged.
- Owner drop while a snoop grant is held: both grants clear at the same edge.

## Test plan
- Single request:
  - Stimulus: after reset, req_proc_dl=4'b0100 from cycle 2.
  - Required: gnt_proc_dl=4'b0100 in cycle 3, bus_owner_id=2, bus_busy=1.
  - Drop at cycle 6 → grants 0 in cycle 7.
- Round-robin fairness:
  - Stimulus: all 8 proc requests held high, each owner dropping 2 cycles after its grant.
  - Required grant order: dl0, il0, dl1, il1, dl2, il2, dl3, il3, dl0.
  - Required gap: exactly 2 grant-low cycles between owners.
- Snoop sequencing:
  - Stimulus: owner dl1 granted, then req_snoop=4'b1011.
  - Required: snoop grants in order core 3 then core 0 (core 1 masked).
  - Each snoop grant is separated by 1 idle cycle; never two snoop grant bits high.
- Snoop outside a transaction: req_snoop=4'b0001 while idle → gnt_snoop stays 0 until a proc grant exists.
- Owner abort: owner dl2 with snoop core 0 granted; owner drops → both grants low the next cycle, state passes through RELEASE.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while dl3 and snoop 1 are granted.
  - Required: all outputs 0 after that edge.
  - With all requests high afterward, the first grant goes to dl0.

Source files
------------

// File: rtl/lv1_lv2_bus_arbiter.sv
// ============================================================================
// Module   : lv1_lv2_bus_arbiter
// Brief    : Round-robin processor/snoop arbiter for the shared lv1-lv2 bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lv1_lv2_bus_arbiter #(
    parameter int NUM_CORES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_proc_dl,
    input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_proc_il,
    input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_snoop,
    output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_proc_dl,
    output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_proc_il,
    output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_snoop,
    output logic [1:0]           bus_owner_id,
    output logic                 bus_owner_il,
    output logic                 bus_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t     r_state, w_state;
    logic [2:0] r_last_proc, w_last_proc;
    logic [1:0] r_last_snoop, w_last_snoop;
    logic [1:0] r_owner_id, w_owner_id;
    logic       r_owner_il, w_owner_il;
    logic       r_snp_act, w_snp_act;
    logic [1:0] r_snp_id, w_snp_id;
    logic [3:0] r_gnt_dl, r_gnt_il, r_gnt_snoop;
    logic [3:0] w_gnt_dl, w_gnt_il, w_gnt_snoop;

    logic [7:0] w_req_proc;
    logic       w_proc_found;
    logic [2:0] w_proc_idx;
    logic       w_snoop_found;
    logic [1:0] w_snoop_idx;

    // Requester r = 2*core + il, so the flat vector interleaves dl/il per core.
    always_comb begin
        w_req_proc = '0;
        for (int c = 0; c < 4; c++) begin
            w_req_proc[2*c]   = bus_lv1_lv2_req_proc_dl[c];
            w_req_proc[2*c+1] = bus_lv1_lv2_req_proc_il[c];
        end
    end

    always_comb begin
        w_proc_found = 1'b0;
        w_proc_idx   = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            if (!w_proc_found && w_req_proc[r_last_proc + 3'(i)]) begin
                w_proc_found = 1'b1;
                w_proc_idx   = r_last_proc + 3'(i);
            end
        end
    end

    // The owner's own core can never be its own snoop responder.
    always_comb begin
        w_snoop_found = 1'b0;
        w_snoop_idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_snoop_found && bus_lv1_lv2_req_snoop[r_last_snoop + 2'(i)]
                && ((r_last_snoop + 2'(i)) != r_owner_id)) begin
                w_snoop_found = 1'b1;
                w_snoop_idx   = r_last_snoop + 2'(i);
            end
        end
    end

    always_comb begin
        w_state      = r_state;
        w_last_proc  = r_last_proc;
        w_last_snoop = r_last_snoop;
        w_owner_id   = r_owner_id;
        w_owner_il   = r_owner_il;
        w_snp_act    = r_snp_act;
        w_snp_id     = r_snp_id;
        case (r_state)
            S_IDLE: begin
                if (w_proc_found) begin
                    w_state     = S_GRANT;
                    w_last_proc = w_proc_idx;
                    w_owner_id  = w_proc_idx[2:1];
                    w_owner_il  = w_proc_idx[0];
                    w_snp_act   = 1'b0;
                end
            end
            S_GRANT: begin
                if (!w_req_proc[{r_owner_id, r_owner_il}]) begin
                    w_state    = S_RELEASE;
                    w_owner_id = 2'd0;
                    w_owner_il = 1'b0;
                    w_snp_act  = 1'b0;
                    w_snp_id   = 2'd0;
                end else if (!r_snp_act) begin
                    if (w_snoop_found) begin
                        w_snp_act    = 1'b1;
                        w_snp_id     = w_snoop_idx;
                        w_last_snoop = w_snoop_idx;
                    end
                end else if (!bus_lv1_lv2_req_snoop[r_snp_id]) begin
                    w_snp_act = 1'b0;
                end
            end
            S_RELEASE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_gnt_dl    = '0;
        w_gnt_il    = '0;
        w_gnt_snoop = '0;
        if (w_state == S_GRANT) begin
            if (w_owner_il) w_gnt_il = 4'b0001 << w_owner_id;
            else            w_gnt_dl = 4'b0001 << w_owner_id;
            if (w_snp_act)  w_gnt_snoop = 4'b0001 << w_snp_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_proc  <= 3'd7;
            r_last_snoop <= 2'd3;
            r_owner_id   <= 2'd0;
            r_owner_il   <= 1'b0;
            r_snp_act    <= 1'b0;
            r_snp_id     <= 2'd0;
            r_gnt_dl     <= '0;
            r_gnt_il     <= '0;
            r_gnt_snoop  <= '0;
        end else begin
            r_state      <= w_state;
            r_last_proc  <= w_last_proc;
            r_last_snoop <= w_last_snoop;
            r_owner_id   <= w_owner_id;
            r_owner_il   <= w_owner_il;
            r_snp_act    <= w_snp_act;
            r_snp_id     <= w_snp_id;
            r_gnt_dl     <= w_gnt_dl;
            r_gnt_il     <= w_gnt_il;
            r_gnt_snoop  <= w_gnt_snoop;
        end
    end

    assign bus_lv1_lv2_gnt_proc_dl = r_gnt_dl;
    assign bus_lv1_lv2_gnt_proc_il = r_gnt_il;
    assign bus_lv1_lv2_gnt_snoop   = r_gnt_snoop;
    assign bus_owner_id            = r_owner_id;
    assign bus_owner_il            = r_owner_il;
    assign bus_busy                = |(r_gnt_dl | r_gnt_il);

endmodule

`default_nettype wire

// File: tb/tb_lv1_lv2_bus_arbiter.sv
// ============================================================================
// Module   : tb_lv1_lv2_bus_arbiter
// Brief    : Directed self-checking bench for lv1_lv2_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lv1_lv2_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_dl = '0, req_il = '0, req_snoop = '0;
    logic [3:0] gnt_dl, gnt_il, gnt_snoop;
    logic [1:0] owner_id;
    logic       owner_il, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lv1_lv2_bus_arbiter #(.NUM_CORES(4)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .bus_lv1_lv2_req_proc_dl (req_dl),
        .bus_lv1_lv2_req_proc_il (req_il),
        .bus_lv1_lv2_req_snoop   (req_snoop),
        .bus_lv1_lv2_gnt_proc_dl (gnt_dl),
        .bus_lv1_lv2_gnt_proc_il (gnt_il),
        .bus_lv1_lv2_gnt_snoop   (gnt_snoop),
        .bus_owner_id            (owner_id),
        .bus_owner_il            (owner_il),
        .bus_busy                (busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] flat_gnt();
        logic [7:0] g;
        for (int c = 0; c < 4; c++) begin
            g[2*c]   = gnt_dl[c];
            g[2*c+1] = gnt_il[c];
        end
        return g;
    endfunction

    // Advance one edge, then check the bus invariants away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        check("inv_proc_onehot", 8'($countones(gnt_dl | gnt_il) <= 1), 8'd1);
        check("inv_snoop_onehot", 8'($countones(gnt_snoop) <= 1), 8'd1);
        check("inv_snoop_needs_busy", 8'((gnt_snoop == 4'd0) || busy), 8'd1);
        check("inv_snoop_not_owner", 8'((gnt_snoop & (4'b0001 << owner_id)) == 4'd0), 8'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"}, {gnt_dl | gnt_il, gnt_snoop}, 8'h00);
        check({tag, "_owner"}, {5'd0, owner_id, owner_il}, 8'h00);
        check({tag, "_busy"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        int gap;
        bit found;
        logic [7:0] g;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check_idle("reset");

        // Single request
        req_dl = 4'b0100;
        tick();
        check("single_gnt_dl", {4'd0, gnt_dl}, 8'h04);
        check("single_owner", {5'd0, owner_id, owner_il}, {5'd0, 2'd2, 1'b0});
        check("single_busy", {7'd0, busy}, 8'h01);
        tick(); tick();
        check("single_hold", {4'd0, gnt_dl}, 8'h04);
        req_dl = 4'b0000;
        tick();
        check_idle("single_release");
        tick();
        check_idle("single_idle");

        // Round-robin fairness with all eight requesters
        rst = 1'b1; tick(); rst = 1'b0;
        req_dl = 4'hF; req_il = 4'hF;
        gap = 0;
        for (int k = 0; k <= 8; k++) begin
            int exp_r;
            exp_r = k % 8;
            found = 1'b0;
            for (int t = 0; t < 10 && !found; t++) begin
                tick();
                if (flat_gnt() != 8'd0) found = 1'b1;
                else gap++;
            end
            check("rr_found", {7'd0, found}, 8'h01);
            check("rr_gnt", flat_gnt(), 8'b1 << exp_r);
            check("rr_owner", {5'd0, owner_id, owner_il}, 8'(exp_r));
            check("rr_gap", 8'(gap), (k == 0) ? 8'd0 : 8'd2);
            tick();
            check("rr_hold", flat_gnt(), 8'b1 << exp_r);
            if (exp_r % 2 == 0) req_dl[exp_r/2] = 1'b0;
            else                req_il[exp_r/2] = 1'b0;
            tick();
            check("rr_drop", flat_gnt(), 8'h00);
            gap = 1;
            if (exp_r % 2 == 0) req_dl[exp_r/2] = 1'b1;
            else                req_il[exp_r/2] = 1'b1;
        end
        req_dl = '0; req_il = '0;

        // Snoop sequencing under owner dl1; prime last_snoop to core 2 first
        rst = 1'b1; tick(); rst = 1'b0;
        req_dl = 4'b0010;
        tick();
        check("snp_owner", {5'd0, owner_id, owner_il}, {5'd0, 2'd1, 1'b0});
        req_snoop = 4'b0100;
        tick();
        check("snp_prime", {4'd0, gnt_snoop}, 8'h04);
        req_snoop = 4'b0000;
        tick();
        check("snp_prime_rel", {4'd0, gnt_snoop}, 8'h00);
        req_snoop = 4'b1011;
        tick();
        check("snp_first_core3", {4'd0, gnt_snoop}, 8'h08);
        req_snoop = 4'b0011;
        tick();
        check("snp_idle_gap", {4'd0, gnt_snoop}, 8'h00);
        tick();
        check("snp_second_core0", {4'd0, gnt_snoop}, 8'h01);
        req_snoop = 4'b0010;
        tick();
        check("snp_rel_core0", {4'd0, gnt_snoop}, 8'h00);
        tick();
        check("snp_owner_masked", {4'd0, gnt_snoop}, 8'h00);
        check("snp_owner_kept", {4'd0, gnt_dl}, 8'h02);

        // Snoop outside a transaction
        req_dl = 4'b0000;
        req_snoop = 4'b0001;
        tick();
        check_idle("snp_out_release");
        tick();
        tick();
        check_idle("snp_out_idle");
        req_dl = 4'b0100;
        tick();
        check("snp_out_first_cycle", {gnt_dl, gnt_snoop}, 8'h40);
        tick();
        check("snp_out_granted", {gnt_dl, gnt_snoop}, 8'h41);

        // Owner abort while snoop core 0 is held, then turnaround to a new owner
        req_dl = 4'b0000;
        tick();
        check_idle("abort_clear");
        req_dl = 4'b0001;
        req_snoop = 4'b0000;
        tick();
        check_idle("abort_turnaround");
        tick();
        check("abort_next_owner", {gnt_dl, gnt_snoop}, 8'h10);
        req_dl = 4'b0000;
        tick(); tick();

        // Reset mid-operation with dl3 owner and snoop 1 held
        req_dl = 4'b1000;
        tick();
        check("mid_owner", {gnt_dl, 2'd0, owner_id}, 8'h83);
        req_snoop = 4'b0010;
        tick();
        check("mid_snoop", {4'd0, gnt_snoop}, 8'h02);
        rst = 1'b1;
        tick();
        check_idle("mid_reset");
        rst = 1'b0;
        req_dl = 4'hF; req_il = 4'hF; req_snoop = 4'hF;
        tick();
        check("post_reset_first", flat_gnt(), 8'h01);
        tick();
        check("post_reset_snoop", {4'd0, gnt_snoop}, 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
